// File: rtl/aes_ctrl_pkg.sv
// Purpose: shared types and widths for the AES encryption scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_ctrl_pkg;

    localparam int BLK_W = 128;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_KEY = 3'd1,
        START    = 3'd2,
        BUSY     = 3'd3,
        RESP     = 3'd4
    } sched_state_t;

endpackage

// File: rtl/aes_enc_scheduler_if.sv
// Purpose: requester-side bus of the AES scheduler (block requests in, ciphertext out).
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready for requests, rsp_valid/rsp_ready for responses.
// Ports: req_valid/req_plain/req_key and rsp_ready driven by requesters (master);
//        req_ready/rsp_valid/rsp_cipher/rsp_err driven by the scheduler (slave).
interface aes_enc_scheduler_if #(
    parameter int NUM_REQ = 2,
    parameter int BLK_W   = 128
);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*BLK_W-1:0] req_plain;
    logic [NUM_REQ*BLK_W-1:0] req_key;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [NUM_REQ-1:0]       rsp_ready;
    logic [BLK_W-1:0]         rsp_cipher;
    logic                     rsp_err;

    modport master (
        output req_valid, req_plain, req_key, rsp_ready,
        input  req_ready, rsp_valid, rsp_cipher, rsp_err
    );

    modport slave (
        input  req_valid, req_plain, req_key, rsp_ready,
        output req_ready, rsp_valid, rsp_cipher, rsp_err
    );

endinterface

// File: rtl/rr_arbiter.sv
// Purpose: round-robin pick of the first requesting index after the pointer, with wrap.
// Latency: combinational.
// Backpressure: none; the caller decides when the grant is consumed.
// Ports: i_req request vector, i_ptr last-granted index; o_gnt one-hot grant,
//        o_idx grant index, o_any at least one request present.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [IW-1:0] w_cand;

    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = '0;
        // Scan ptr+1 .. ptr+N so the last-granted index has the lowest priority.
        for (int k = 1; k <= N; k++) begin
            w_cand = IW'((int'(i_ptr) + k) % N);
            if (!o_any && i_req[w_cand]) begin
                o_any         = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
            end
        end
    end

endmodule

// File: rtl/aes_enc_scheduler.sv
// Purpose: shares one AES encryption core + key expansion among NUM_REQ requesters.
// Latency: accept to rsp_valid = 2 + Tcore (same key) or 3 + Tcore (key reload).
// Backpressure: one block in flight; no new grant until the response handshake completes.
// Ports: clk/reset_n; bus (requester side, slave modport); core_* and key_out/set_new_key
//        toward the encryption and key_expansion units.
module aes_enc_scheduler #(
    parameter int NUM_REQ     = 2,
    parameter int BLK_W       = aes_ctrl_pkg::BLK_W,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    aes_enc_scheduler_if.slave bus,
    output logic [BLK_W-1:0]   core_plain_text,
    output logic               core_start,
    input  logic               core_ready_enc,
    input  logic               core_done_enc,
    input  logic [BLK_W-1:0]   core_cipher_text,
    output logic [BLK_W-1:0]   key_out,
    output logic               set_new_key
);

    import aes_ctrl_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;

    sched_state_t        r_state;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    r_gnt_idx;
    logic                r_key_loaded;
    logic [TMR_W-1:0]    r_timer;
    logic                r_done_q;
    logic [BLK_W-1:0]    r_plain;
    logic [BLK_W-1:0]    r_key;
    logic                r_set_key;
    logic                r_start;
    logic [NUM_REQ-1:0]  r_rsp_valid;
    logic [BLK_W-1:0]    r_rsp_cipher;
    logic                r_rsp_err;

    logic [NUM_REQ-1:0]  w_gnt;
    logic [IDX_W-1:0]    w_idx;
    logic                w_any;
    logic [BLK_W-1:0]    w_plain_sel;
    logic [BLK_W-1:0]    w_key_sel;
    logic                w_done_edge;
    logic [TMR_W-1:0]    w_timer_inc;
    logic                w_unused_ready;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .i_req (bus.req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_plain_sel = bus.req_plain[w_idx*BLK_W +: BLK_W];
    assign w_key_sel   = bus.req_key[w_idx*BLK_W +: BLK_W];
    assign w_done_edge = core_done_enc & ~r_done_q;
    assign w_timer_inc = (&r_timer) ? r_timer : r_timer + 1'b1;

    // The core owns stall behaviour; start is issued regardless of ready_enc.
    assign w_unused_ready = core_ready_enc;

    // Accept is a same-cycle decode of the grant so the request data is
    // captured on the very edge the requester sees ready.
    assign bus.req_ready  = (r_state == IDLE) ? w_gnt : '0;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_cipher = r_rsp_cipher;
    assign bus.rsp_err    = r_rsp_err;

    assign core_plain_text = r_plain;
    assign core_start      = r_start;
    assign key_out         = r_key;
    assign set_new_key     = r_set_key;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_ptr        <= IDX_W'(NUM_REQ - 1);
            r_gnt_idx    <= '0;
            r_key_loaded <= 1'b0;
            r_timer      <= '0;
            r_done_q     <= 1'b0;
            r_plain      <= '0;
            r_key        <= '0;
            r_set_key    <= 1'b0;
            r_start      <= 1'b0;
            r_rsp_valid  <= '0;
            r_rsp_cipher <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_done_q <= core_done_enc;
            case (r_state)
                IDLE: begin
                    // Timer reads 0 in the START cycle, so in BUSY it equals
                    // the number of cycles since core_start.
                    r_timer <= '0;
                    if (w_any) begin
                        r_gnt_idx <= w_idx;
                        r_ptr     <= w_idx;
                        r_plain   <= w_plain_sel;
                        if (!r_key_loaded || (w_key_sel != r_key)) begin
                            // key_out only moves as LOAD_KEY begins.
                            r_key     <= w_key_sel;
                            r_set_key <= 1'b1;
                            r_state   <= LOAD_KEY;
                        end else begin
                            r_start <= 1'b1;
                            r_state <= START;
                        end
                    end
                end
                LOAD_KEY: begin
                    r_set_key    <= 1'b0;
                    r_key_loaded <= 1'b1;
                    r_start      <= 1'b1;
                    r_state      <= START;
                end
                START: begin
                    r_start <= 1'b0;
                    r_timer <= w_timer_inc;
                    r_state <= BUSY;
                end
                BUSY: begin
                    r_timer <= w_timer_inc;
                    if (w_done_edge) begin
                        r_rsp_cipher <= core_cipher_text;
                        r_rsp_err    <= 1'b0;
                        r_rsp_valid  <= NUM_REQ'(1) << r_gnt_idx;
                        r_state      <= RESP;
                    end else if (r_timer == TMR_W'(TIMEOUT_CYC - 1)) begin
                        // Core state is unknown after a hang: force a key reload.
                        r_rsp_cipher <= '0;
                        r_rsp_err    <= 1'b1;
                        r_key_loaded <= 1'b0;
                        r_rsp_valid  <= NUM_REQ'(1) << r_gnt_idx;
                        r_state      <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready[r_gnt_idx]) begin
                        r_rsp_valid <= '0;
                        r_rsp_err   <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_enc_scheduler.sv
// Purpose: scoreboard bench for aes_enc_scheduler with a behavioural FIPS-197 core stub.
// Latency: stub core answers TCORE cycles after core_start.
// Backpressure: rsp_ready driven per scenario.
module tb_aes_enc_scheduler;

    localparam int NUM_REQ     = 2;
    localparam int BLK_W       = 128;
    localparam int TIMEOUT_CYC = 64;
    localparam int TCORE       = 4;

    localparam logic [BLK_W-1:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [BLK_W-1:0] P1  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [BLK_W-1:0] C1  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [BLK_W-1:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [BLK_W-1:0] P2  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [BLK_W-1:0] C2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [BLK_W-1:0] BAD = 128'hbadbadbadbadbadbadbadbadbadbadba;

    typedef struct {
        int               idx;
        logic [BLK_W-1:0] cipher;
        logic             err;
    } exp_t;

    logic             clk;
    logic             reset_n;
    logic [BLK_W-1:0] core_plain_text;
    logic             core_start;
    logic             core_ready_enc;
    logic             core_done_enc;
    logic [BLK_W-1:0] core_cipher_text;
    logic [BLK_W-1:0] key_out;
    logic             set_new_key;

    aes_enc_scheduler_if #(.NUM_REQ(NUM_REQ), .BLK_W(BLK_W)) bus ();

    aes_enc_scheduler #(
        .NUM_REQ     (NUM_REQ),
        .BLK_W       (BLK_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .bus              (bus.slave),
        .core_plain_text  (core_plain_text),
        .core_start       (core_start),
        .core_ready_enc   (core_ready_enc),
        .core_done_enc    (core_done_enc),
        .core_cipher_text (core_cipher_text),
        .key_out          (key_out),
        .set_new_key      (set_new_key)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb_q[$];
    int   grant_q[$];
    int   rsp_done = 0;
    int   acc_cyc = 0;
    int   rise_cyc = 0;
    int   start_cyc = 0;
    int   start_cnt = 0;
    int   snk_cnt = 0;
    logic hang = 1'b0;
    logic [NUM_REQ-1:0] prev_v = '0;
    exp_t mon_e;

    task automatic check(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [NUM_REQ-1:0] onehot(input int i);
        return NUM_REQ'(1) << i;
    endfunction

    // Behavioural core: only the two FIPS-197 vectors are known; any other
    // key/plain pairing (e.g. a stale key) answers with a marker value.
    function automatic logic [BLK_W-1:0] ref_cipher(input logic [BLK_W-1:0] k, input logic [BLK_W-1:0] p);
        if (k == K1 && p == P1) return C1;
        if (k == K2 && p == P2) return C2;
        return BAD;
    endfunction

    logic [BLK_W-1:0] stub_key, stub_plain;
    int               stub_cnt;
    logic             stub_run;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stub_key         <= '0;
            stub_plain       <= '0;
            stub_cnt         <= 0;
            stub_run         <= 1'b0;
            core_done_enc    <= 1'b0;
            core_cipher_text <= '0;
        end else begin
            core_done_enc <= 1'b0;
            if (set_new_key) stub_key <= key_out;
            if (core_start) begin
                stub_plain <= core_plain_text;
                stub_cnt   <= TCORE - 1;
                stub_run   <= 1'b1;
            end else if (stub_run) begin
                if (stub_cnt == 1) begin
                    stub_run <= 1'b0;
                    if (!hang) begin
                        core_done_enc    <= 1'b1;
                        core_cipher_text <= ref_cipher(stub_key, stub_plain);
                    end
                end else begin
                    stub_cnt <= stub_cnt - 1;
                end
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: event logging and scoreboard pop on every response handshake.
    always @(negedge clk) begin
        if (reset_n) begin
            if (set_new_key) snk_cnt++;
            if (core_start) begin
                start_cnt++;
                start_cyc = cyc;
            end
            for (int i = 0; i < NUM_REQ; i++)
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    grant_q.push_back(i);
                    acc_cyc = cyc;
                end
            if (bus.rsp_valid != '0 && prev_v == '0) rise_cyc = cyc;
            if ((bus.rsp_valid & bus.rsp_ready) != '0) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got rsp_valid %b expected none", bus.rsp_valid);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("rsp_valid_owner", BLK_W'(bus.rsp_valid), BLK_W'(onehot(mon_e.idx)));
                    check("rsp_cipher", bus.rsp_cipher, mon_e.cipher);
                    check("rsp_err", BLK_W'(bus.rsp_err), BLK_W'(mon_e.err));
                end
                rsp_done++;
            end
        end
        prev_v = bus.rsp_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic raise(input int idx, input logic [BLK_W-1:0] k, input logic [BLK_W-1:0] p);
        bus.req_plain[idx*BLK_W +: BLK_W] = p;
        bus.req_key[idx*BLK_W +: BLK_W]   = k;
        bus.req_valid[idx]                = 1'b1;
    endtask

    task automatic wait_grants(input int target, input string name);
        int n;
        n = 0;
        while (grant_q.size() < target && n < 300) begin
            step();
            n++;
        end
        if (grant_q.size() < target) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d grants expected %0d", name, grant_q.size(), target);
        end
    endtask

    task automatic wait_rsp(input int target, input string name);
        int n;
        n = 0;
        while (rsp_done < target && n < 300) begin
            step();
            n++;
        end
        if (rsp_done < target) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d responses expected %0d", name, rsp_done, target);
        end
        step();
    endtask

    // One request from idx, response expected as given; returns accept->rsp latency.
    task automatic send(input int idx, input logic [BLK_W-1:0] k, input logic [BLK_W-1:0] p,
                        input logic [BLK_W-1:0] c, input logic err, input string name, output int lat);
        exp_t e;
        int   g0, r0;
        e.idx = idx; e.cipher = c; e.err = err;
        sb_q.push_back(e);
        g0 = grant_q.size();
        r0 = rsp_done;
        raise(idx, k, p);
        wait_grants(g0 + 1, name);
        bus.req_valid[idx] = 1'b0;
        wait_rsp(r0 + 1, name);
        lat = rise_cyc - acc_cyc;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_rsp_valid"}, BLK_W'(bus.rsp_valid), '0);
        check({name, "_rsp_cipher"}, bus.rsp_cipher, '0);
        check({name, "_rsp_err"}, BLK_W'(bus.rsp_err), '0);
        check({name, "_core_start"}, BLK_W'(core_start), '0);
        check({name, "_set_new_key"}, BLK_W'(set_new_key), '0);
        check({name, "_key_out"}, key_out, '0);
        check({name, "_plain"}, core_plain_text, '0);
        check({name, "_req_ready"}, BLK_W'(bus.req_ready), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int lat, s0, t0, g0, n;
        logic stable, rdy_zero;
        int exp_order[4];
        exp_t e;

        reset_n        = 1'b0;
        core_ready_enc = 1'b1;
        bus.req_valid  = '0;
        bus.req_plain  = '0;
        bus.req_key    = '0;
        bus.rsp_ready  = '1;
        repeat (3) step();
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) step();

        // Single request: fresh scheduler must load the key first.
        s0 = snk_cnt; t0 = start_cnt;
        send(0, K1, P1, C1, 1'b0, "single", lat);
        check("single_set_new_key_pulses", BLK_W'(snk_cnt - s0), BLK_W'(1));
        check("single_start_pulses", BLK_W'(start_cnt - t0), BLK_W'(1));
        check("single_latency", BLK_W'(lat), BLK_W'(3 + TCORE));

        // Same key again: no reload, one cycle faster.
        s0 = snk_cnt; t0 = start_cnt;
        send(0, K1, P1, C1, 1'b0, "reuse", lat);
        check("reuse_set_new_key_pulses", BLK_W'(snk_cnt - s0), BLK_W'(0));
        check("reuse_start_pulses", BLK_W'(start_cnt - t0), BLK_W'(1));
        check("reuse_latency", BLK_W'(lat), BLK_W'(2 + TCORE));

        // Contention: last grant was 0, so rotation begins at 1.
        exp_order = '{1, 0, 1, 0};
        for (int i = 0; i < 4; i++) begin
            e.idx    = exp_order[i];
            e.cipher = (exp_order[i] == 1) ? C2 : C1;
            e.err    = 1'b0;
            sb_q.push_back(e);
        end
        s0 = snk_cnt; t0 = start_cnt; g0 = grant_q.size();
        n = rsp_done;
        raise(0, K1, P1);
        raise(1, K2, P2);
        wait_grants(g0 + 4, "contention");
        bus.req_valid = '0;
        wait_rsp(n + 4, "contention");
        for (int i = 0; i < 4; i++)
            if (g0 + i < grant_q.size())
                check($sformatf("contention_grant%0d", i), BLK_W'(grant_q[g0 + i]), BLK_W'(exp_order[i]));
        check("contention_set_new_key_pulses", BLK_W'(snk_cnt - s0), BLK_W'(4));
        check("contention_start_pulses", BLK_W'(start_cnt - t0), BLK_W'(4));

        // Backpressure on requester 0; rsp_ready[1] high must not complete it.
        e.idx = 0; e.cipher = C1; e.err = 1'b0; sb_q.push_back(e);
        e.idx = 1; e.cipher = C2; e.err = 1'b0; sb_q.push_back(e);
        bus.rsp_ready = 2'b10;
        g0 = grant_q.size();
        n  = rsp_done;
        raise(0, K1, P1);
        wait_grants(g0 + 1, "bp_accept");
        bus.req_valid[0] = 1'b0;
        lat = 0;
        while (!bus.rsp_valid[0] && lat < 100) begin
            step();
            lat++;
        end
        raise(1, K2, P2);
        stable = 1'b1;
        rdy_zero = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.rsp_valid !== 2'b01 || bus.rsp_cipher !== C1 || bus.rsp_err !== 1'b0) stable = 1'b0;
            if (bus.req_ready !== '0) rdy_zero = 1'b0;
        end
        check("bp_rsp_stable", BLK_W'(stable), BLK_W'(1));
        check("bp_req_ready_low", BLK_W'(rdy_zero), BLK_W'(1));
        check("bp_no_handshake", BLK_W'(rsp_done - n), BLK_W'(0));
        bus.rsp_ready = '1;
        wait_grants(g0 + 2, "bp_second");
        bus.req_valid[1] = 1'b0;
        wait_rsp(n + 2, "bp");

        // Timeout: core never answers; error response TIMEOUT_CYC cycles after start.
        hang = 1'b1;
        send(0, K2, P2, '0, 1'b1, "timeout", lat);
        check("timeout_start_to_rsp", BLK_W'(rise_cyc - start_cyc), BLK_W'(TIMEOUT_CYC));
        hang = 1'b0;
        s0 = snk_cnt;
        send(0, K2, P2, C2, 1'b0, "after_timeout", lat);
        check("after_timeout_reload", BLK_W'(snk_cnt - s0), BLK_W'(1));

        // Reset while BUSY: no response, outputs cleared at once, key reloaded after.
        t0 = start_cnt;
        n  = rsp_done;
        g0 = grant_q.size();
        raise(0, K1, P1);
        wait_grants(g0 + 1, "rst_accept");
        bus.req_valid[0] = 1'b0;
        lat = 0;
        while (start_cnt == t0 && lat < 50) begin
            step();
            lat++;
        end
        step();
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (TCORE + 4) step();
        reset_n = 1'b1;
        repeat (2) step();
        check("midreset_no_response", BLK_W'(rsp_done - n), BLK_W'(0));
        s0 = snk_cnt;
        send(0, K1, P1, C1, 1'b0, "after_reset", lat);
        check("after_reset_reload", BLK_W'(snk_cnt - s0), BLK_W'(1));

        check("scoreboard_drained", BLK_W'(sb_q.size()), BLK_W'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
